// File: rtl/morse_msg_sequencer.sv
// morse_msg_sequencer: letter queue feeding a Morse transmitter with symbol/gap pacing; optional sticky Overflow via MORSE_SEQ_OVERFLOW_FLAG_EN
module morse_msg_sequencer #(
  parameter int DEPTH       = 4,
  parameter int SYMBOL_BITS = 12,
  parameter int GAP_BITS    = 3
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Push,
  input  logic [2:0] LetterIn,
  input  logic       TxNewBit,
  output logic       TxStart,
  output logic [2:0] TxLetter,
  output logic       Full,
  output logic       Empty,
  output logic       Busy,
  output logic       Done,
  output logic       Overflow
);
  localparam int AW   = $clog2(DEPTH);
  localparam int MAXB = (SYMBOL_BITS > GAP_BITS) ? SYMBOL_BITS : GAP_BITS;
  localparam int CW   = $clog2(MAXB + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  state_t        state;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] strobe_cnt;
  logic          pop, push_ok;
  assign pop     = state == LOAD;
  assign push_ok = Push && (!Full || pop);
  assign Full    = count == (AW+1)'(DEPTH);
  assign Empty   = count == '0;
  assign Busy    = state != IDLE;
  // queue storage; contents are don't-care while the count says empty
  always_ff @(posedge ClockIn)
    if (push_ok) mem[wr_ptr] <= LetterIn;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge ClockIn or posedge Reset)
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  // sequencing FSM; TxStart/TxLetter are loaded on entry to LOAD so they are high exactly during LOAD
  always_ff @(posedge ClockIn or posedge Reset)
    if (Reset) begin
      state      <= IDLE;
      strobe_cnt <= '0;
      TxStart    <= 1'b0;
      TxLetter   <= '0;
      Done       <= 1'b0;
    end else begin
      TxStart  <= 1'b0;
      TxLetter <= '0;
      Done     <= 1'b0;
      case (state)
        IDLE: if (!Empty) begin
          state    <= LOAD;
          TxStart  <= 1'b1;
          TxLetter <= mem[rd_ptr];
        end
        LOAD: begin
          strobe_cnt <= '0;
          state      <= SEND;
        end
        SEND: if (TxNewBit) begin
          strobe_cnt <= (strobe_cnt == CW'(SYMBOL_BITS - 1)) ? '0 : strobe_cnt + 1'b1;
          if (strobe_cnt == CW'(SYMBOL_BITS - 1)) state <= GAP;
        end
        GAP: if (TxNewBit) begin
          strobe_cnt <= (strobe_cnt == CW'(GAP_BITS - 1)) ? '0 : strobe_cnt + 1'b1;
          if (strobe_cnt == CW'(GAP_BITS - 1)) begin
            state    <= Empty ? IDLE : LOAD;
            Done     <= Empty;
            TxStart  <= !Empty;
            TxLetter <= Empty ? 3'd0 : mem[rd_ptr];
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef MORSE_SEQ_OVERFLOW_FLAG_EN
  // sticky record of any push refused because the queue was full
  always_ff @(posedge ClockIn or posedge Reset)
    if (Reset) Overflow <= 1'b0;
    else if (Push && !push_ok) Overflow <= 1'b1;
`else
  assign Overflow = 1'b0;
`endif
endmodule
